// File: rtl/fltr_bounce_gen_pkg.sv
// Shared types for the filter bounce stimulus generator.
package fltr_bounce_gen_pkg;
    typedef logic [7:0] u8_t;
    typedef logic [3:0] u4_t;

    typedef enum logic [1:0] {ST_IDLE, ST_GLITCH, ST_GAP, ST_HOLD} enBNC_STATE;

    localparam int CNT_W_DEF = 8;
    localparam int NB_W_DEF  = 4;
endpackage

// File: rtl/fltr_bounce_gen_dur_cnt.sv
// Loadable duration down-counter; a load of len runs for max(len,1) cycles.
module fltr_bounce_gen_dur_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? '0 : len - CNT_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/fltr_bounce_gen.sv
// Drives the glitch filter input with n bounce pulses, then holds a target level.
module fltr_bounce_gen
    import fltr_bounce_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NB_W  = NB_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             target,
    input  logic [NB_W-1:0]  n_bounce,
    input  logic [CNT_W-1:0] glitch_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [CNT_W-1:0] hold_len,
    output logic             fltr_in,
    output logic             busy,
    output logic             done
);
    enBNC_STATE       state;
    logic             tgt_sh;
    logic             old_sh;
    logic [NB_W-1:0]  bcnt;
    logic [CNT_W-1:0] g_sh;
    logic [CNT_W-1:0] p_sh;
    logic [CNT_W-1:0] h_sh;
    logic             load;
    logic             zero;
    logic [CNT_W-1:0] load_len;

    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // The counter is reloaded on every timed-state entry; at start the shadows
    // are not yet valid so the raw inputs feed it directly.
    always_comb begin
        load     = 1'b0;
        load_len = g_sh;
        case (state)
            ST_IDLE: if (start) begin
                load     = 1'b1;
                load_len = (n_bounce == '0) ? hold_len : glitch_len;
            end
            ST_GLITCH: if (zero) begin
                load     = 1'b1;
                load_len = p_sh;
            end
            ST_GAP: if (zero) begin
                load     = 1'b1;
                load_len = (bcnt != '0) ? g_sh : h_sh;
            end
            default: ;
        endcase
    end

    fltr_bounce_gen_dur_cnt #(.CNT_W(CNT_W)) u_dur_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .len   (load_len),
        .zero  (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tgt_sh  <= 1'b0;
            old_sh  <= 1'b0;
            bcnt    <= '0;
            g_sh    <= '0;
            p_sh    <= '0;
            h_sh    <= '0;
            fltr_in <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    tgt_sh <= target;
                    old_sh <= fltr_in;
                    bcnt   <= n_bounce;
                    g_sh   <= clamp1(glitch_len);
                    p_sh   <= clamp1(gap_len);
                    h_sh   <= clamp1(hold_len);
                    busy   <= 1'b1;
                    if (n_bounce == '0) begin
                        state   <= ST_HOLD;
                        fltr_in <= target;
                    end else begin
                        state   <= ST_GLITCH;
                        fltr_in <= ~fltr_in;
                    end
                end
                ST_GLITCH: if (zero) begin
                    bcnt    <= bcnt - NB_W'(1);
                    state   <= ST_GAP;
                    fltr_in <= old_sh;
                end
                ST_GAP: if (zero) begin
                    if (bcnt != '0) begin
                        state   <= ST_GLITCH;
                        fltr_in <= ~old_sh;
                    end else begin
                        state   <= ST_HOLD;
                        fltr_in <= tgt_sh;
                    end
                end
                ST_HOLD: if (zero) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
